render_arbiter_m: RTL

// Shares the single VGA adapter write port (x, y, colour, writeEn) between N pixel renderers
// (board, select box, pieces, ...). Each renderer requests the port, receives a one-cycle start

---
 rtl/render_arbiter_pkg.sv | 17 +
 rtl/render_arbiter_rr_pick.sv | 33 +++
 rtl/render_arbiter_m.sv | 118 +++++++++++
 3 files changed

// File: rtl/render_arbiter_pkg.sv
// Shared types and screen constants for the VGA port arbiter.
// Imported by the arbiter top and its round-robin picker.
package render_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_S_IDLE    = 2'd0,
        ARB_S_START   = 2'd1,
        ARB_S_GRANT   = 2'd2,
        ARB_S_RELEASE = 2'd3
    } arb_state_e;

    localparam int VGA_X_W  = 9;
    localparam int VGA_Y_W  = 8;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

endpackage

// File: rtl/render_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr wins.
// Scan order is ptr+1, ptr+2, ... wrapping modulo N.
module rr_pick_m #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam logic [IDX_W:0] NV = (IDX_W+1)'(N);

    logic [IDX_W:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= NV) begin
                cand = cand - NV;
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/render_arbiter_m.sv
// Shares the VGA adapter write port among N renderers, round-robin.
// Grant is held until done; a watchdog reclaims a grant that never ends.
module render_arbiter_m
    import render_arbiter_pkg::*;
#(
    parameter int N_CLIENTS        = 3,
    parameter int COLOUR_W         = 3,
    parameter int MAX_GRANT_CYCLES = 131072
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS-1:0]          done,
    input  logic [VGA_X_W*N_CLIENTS-1:0]  cl_x,
    input  logic [VGA_Y_W*N_CLIENTS-1:0]  cl_y,
    input  logic [COLOUR_W*N_CLIENTS-1:0] cl_colour,
    input  logic [N_CLIENTS-1:0]          cl_writeEn,
    output logic [N_CLIENTS-1:0]          start,
    output logic [N_CLIENTS-1:0]          grant,
    output logic [VGA_X_W-1:0]            x,
    output logic [VGA_Y_W-1:0]            y,
    output logic [COLOUR_W-1:0]           colour,
    output logic                          writeEn,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int WD_W  = $clog2(MAX_GRANT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_GRANT_CYCLES - 1);

    arb_state_e state;

    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     ptr;
    logic [WD_W-1:0]      wdog;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [N_CLIENTS-1:0] pick_oh;

    logic [VGA_X_W-1:0]  xs   [N_CLIENTS];
    logic [VGA_Y_W-1:0]  ys   [N_CLIENTS];
    logic [COLOUR_W-1:0] cols [N_CLIENTS];
    logic                gnt_on;

    rr_pick_m #(
        .N     (N_CLIENTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_oh = N_CLIENTS'(1) << pick_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARB_S_IDLE;
            idx         <= '0;
            ptr         <= IDX_W'(N_CLIENTS - 1);
            start       <= '0;
            grant       <= '0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                ARB_S_IDLE: begin
                    if (pick_valid) begin
                        idx   <= pick_idx;
                        start <= pick_oh;
                        grant <= pick_oh;
                        state <= ARB_S_START;
                    end
                end
                ARB_S_START: begin
                    start <= '0;
                    wdog  <= '0;
                    state <= ARB_S_GRANT;
                end
                ARB_S_GRANT: begin
                    wdog <= wdog + WD_W'(1);
                    // done beats a coincident expiry, so no error then
                    if (done[idx]) begin
                        grant <= '0;
                        state <= ARB_S_RELEASE;
                    end else if (wdog == WD_LAST) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        state       <= ARB_S_RELEASE;
                    end
                end
                ARB_S_RELEASE: begin
                    ptr   <= idx;
                    state <= ARB_S_IDLE;
                end
                default: state <= ARB_S_IDLE;
            endcase
        end
    end

    assign busy = (state != ARB_S_IDLE);

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_unpack
        assign xs[i]   = cl_x[VGA_X_W*i +: VGA_X_W];
        assign ys[i]   = cl_y[VGA_Y_W*i +: VGA_Y_W];
        assign cols[i] = cl_colour[COLOUR_W*i +: COLOUR_W];
    end

    // Zero-latency mux keeps the renderer's own pixel timing intact
    assign gnt_on  = grant[idx];
    assign writeEn = gnt_on & cl_writeEn[idx];
    assign x       = gnt_on ? xs[idx]   : '0;
    assign y       = gnt_on ? ys[idx]   : '0;
    assign colour  = gnt_on ? cols[idx] : '0;

endmodule
